// File: rtl/uart_ram_dump.sv
// Reads a range of 16-bit RAM words and sends each one as two 8N1 bytes, low byte first.
// Uses the same bit timing as the RAM loader, so a host can read back a loaded program.
module uart_ram_dump #(
    parameter int unsigned DELAY = 234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  first_addr,
    input  logic [7:0]  last_addr,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BAUD_W = $clog2(DELAY + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                byte_sel_q, byte_sel_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                baud_last_c;
    logic                final_byte_c;
    logic                stop_end_c;

    // State and datapath registers; reset forces the line idle high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            word_q     <= '0;
            addr_q     <= '0;
            end_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign baud_last_c  = (baud_q == BAUD_W'(DELAY));
    assign final_byte_c = byte_sel_q && (addr_q == end_q);
    // tx lags the FSM by one register stage, so the last stop bit gets one extra
    // count to make done/busy fall exactly when that bit finishes on the line.
    assign stop_end_c   = final_byte_c ? (baud_q == BAUD_W'(DELAY + 1)) : baud_last_c;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        addr_d     = addr_q;
        end_d      = end_q;
        tx_d       = 1'b1;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (start) begin
                    addr_d  = first_addr;
                    end_d   = last_addr;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                baud_d  = '0;
                state_d = ST_LATCH;
            end

            ST_LATCH: begin
                baud_d     = '0;
                word_d     = mem_data;
                byte_sel_d = 1'b0;
                state_d    = ST_START;
            end

            ST_START: begin
                tx_d = 1'b0;
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                tx_d = word_q[{byte_sel_q, bit_q}];
                if (baud_last_c) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(7)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (stop_end_c) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = ST_START;
                    end else if (final_byte_c) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_ram_dump.sv
// Bench for uart_ram_dump at DELAY=3: a RAM model feeds the DUT, a line monitor decodes
// tx bytes and checks them against a scoreboard queue filled when each transfer starts.
module tb_uart_ram_dump;

    localparam int unsigned DELAY = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  first_addr;
    logic [7:0]  last_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        tx;
    logic        busy;
    logic        done;

    uart_ram_dump #(.DELAY(DELAY)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one cycle after the address changes.
    logic [15:0] ram [256];
    always @(posedge clk) mem_data <= ram[mem_addr];

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] addr;
    } exp_t;

    typedef struct {
        logic [7:0] first;
        logic [7:0] last;
        int         words;
        int         cycles;
        bit         spam;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Line monitor: samples mid-bit, 4 cycles per bit, aborts on reset.
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_byte;
    logic [7:0] m_addr;
    always @(negedge clk) begin
        if (!reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx == 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_addr   = mem_addr;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 2) begin
                check("start_bit", 32'(tx), 32'(0));
            end else if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0) begin
                m_byte[(m_cnt - 6) / 4] = tx;
            end else if (m_cnt == 38) begin
                exp_t e;
                check("stop_bit", 32'(tx), 32'(1));
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(m_byte), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 32'(m_byte), 32'(e.data));
                    check("rx_addr", 32'(m_addr), 32'(e.addr));
                end
                m_active = 1'b0;
            end
        end
    end

    task automatic push_words(input logic [7:0] first, input int words);
        logic [7:0] a;
        for (int k = 0; k < words; k++) begin
            a = first + 8'(k);
            exp_q.push_back('{data: ram[a][7:0],  addr: a});
            exp_q.push_back('{data: ram[a][15:8], addr: a});
        end
    endtask

    // Starts one transfer at the next edge and returns #1 after the edge where done is seen.
    task automatic xfer(input vec_t v);
        int cyc;
        push_words(v.first, v.words);
        start      = 1'b1;
        first_addr = v.first;
        last_addr  = v.last;
        @(posedge clk); #1;
        start      = 1'b0;
        first_addr = ~v.first;
        last_addr  = ~v.last;
        check("busy_after_E", 32'(busy), 32'(1));
        check("addr_after_E", 32'(mem_addr), 32'(v.first));
        check("done_low_after_E", 32'(done), 32'(0));
        cyc = 0;
        while (done !== 1'b1 && cyc < v.cycles + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) check("tx_high_E2", 32'(tx), 32'(1));
            if (cyc == 3) check("tx_low_E3", 32'(tx), 32'(0));
            if (v.spam && (cyc % 5) == 1 && done !== 1'b1) begin
                start      = 1'b1;
                first_addr = 8'($urandom);
                last_addr  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_cycle", 32'(cyc), 32'(v.cycles));
        check("busy_at_done", 32'(busy), 32'(0));
        check("tx_at_done", 32'(tx), 32'(1));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    vec_t vecs[6];

    initial begin
        int   cyc;
        vec_t v;

        vecs[0] = '{first: 8'h05, last: 8'h05, words: 1,   cycles: 83,    spam: 1'b0};
        vecs[1] = '{first: 8'h10, last: 8'h12, words: 3,   cycles: 247,   spam: 1'b0};
        vecs[2] = '{first: 8'hFE, last: 8'h01, words: 4,   cycles: 329,   spam: 1'b0};
        vecs[3] = '{first: 8'h40, last: 8'h43, words: 4,   cycles: 329,   spam: 1'b1};
        vecs[4] = '{first: 8'h80, last: 8'h81, words: 2,   cycles: 165,   spam: 1'b0};
        vecs[5] = '{first: 8'h00, last: 8'hFF, words: 256, cycles: 20993, spam: 1'b0};

        for (int i = 0; i < 256; i++) ram[i] = {~8'(i), 8'(i)};
        ram[8'h05] = 16'hA55A;
        ram[8'h10] = 16'h0100;
        ram[8'h11] = 16'h0302;
        ram[8'h12] = 16'h0504;

        reset      = 1'b0;
        start      = 1'b0;
        first_addr = 8'h00;
        last_addr  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b1;

        // Idle with no start: outputs stay at reset values.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("idle_tx", 32'(tx), 32'(1));
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_done", 32'(done), 32'(0));
            check("idle_addr", 32'(mem_addr), 32'(0));
        end

        // Back-to-back table: each start lands on the edge right after the previous done.
        for (int i = 0; i < 6; i++) xfer(vecs[i]);

        // Reset during DATA of the second word, then a fresh transfer.
        push_words(8'h20, 4);
        start      = 1'b1;
        first_addr = 8'h20;
        last_addr  = 8'h23;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!(cyc >= 90 && tx == 1'b0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tx_low_word2", 32'(tx), 32'(0));
        check("addr_word2", 32'(mem_addr), 32'(8'h21));
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'(1));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_addr", 32'(mem_addr), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tx", 32'(tx), 32'(1));
        v = '{first: 8'h30, last: 8'h31, words: 2, cycles: 165, spam: 1'b0};
        xfer(v);

        repeat (5) @(posedge clk);
        #1;
        check("final_done_low", 32'(done), 32'(0));
        check("final_busy_low", 32'(busy), 32'(0));
        check("done_count", 32'(done_cnt), 32'(7));
        check("final_queue", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
